// File: rtl/crossy_robbers_soc_debug_pkg.sv
// Shared definitions for the crossy_robbers debug JTAG host.
// Contents: host FSM state enum, default shift-register and instruction
// widths, and the virtual-IR opcodes understood by the debug slave.
package crossy_robbers_soc_debug_pkg;

  localparam int DEF_SR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } jtag_state_e;

endpackage

// File: rtl/crossy_robbers_soc_debug_jtag_host_tckgen.sv
// Virtual-JTAG clock divider.
// Ports:
//   clk, reset_n  - system clock, synchronous active-low reset
//   en            - run the divider; when low the counter parks at 0, tck low
//   tck           - registered tck level (low TCK_DIV cycles, high TCK_DIV cycles)
//   rise          - high in the clk cycle whose closing edge raises tck
//   period_end    - high in the clk cycle whose closing edge drops tck
module crossy_robbers_soc_debug_jtag_host_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic period_end
);

  localparam int CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] LAST    = CW'(2 * TCK_DIV - 1);

  logic [CW-1:0] cnt;

  // Strobes are decoded from the counter so the FSM can act on the very
  // edge that moves tck.
  assign rise       = en && (cnt == RISE_AT);
  assign period_end = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en || period_end) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (rise) tck <= 1'b1;
    end
  end

endmodule

// File: rtl/crossy_robbers_soc_debug_jtag_host.sv
// Debug JTAG host: turns one {instruction, DR word} command into a
// virtual-JTAG UIR/CDR/SDR/UDR/RTI sequence and returns the captured DR word.
// Ports:
//   clk, reset_n                    - clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_data      - command handshake
//   resp_valid/resp_ready/resp_data/resp_ir_out - response handshake
//   vji_tck/tdi/rti/uir/cdr/sdr/udr/ir_in    - drive to the debug slave
//   vji_tdo/vji_ir_out              - returned by the debug slave
module crossy_robbers_soc_debug_jtag_host
  import crossy_robbers_soc_debug_pkg::*;
#(
  parameter int SR_WIDTH = DEF_SR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [SR_WIDTH-1:0] resp_data,
  output logic [IR_WIDTH-1:0] resp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int CW = $clog2(SR_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SR_WIDTH - 1);

  jtag_state_e         state;
  logic                pending;
  logic [SR_WIDTH-1:0] shift_q;
  logic [CW-1:0]       bit_cnt;
  logic                tdo_bit;
  logic                tck_en;
  logic                tck_rise;
  logic                tck_end;

  assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

  crossy_robbers_soc_debug_jtag_host_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (tck_en),
    .tck       (vji_tck),
    .rise      (tck_rise),
    .period_end(tck_end)
  );

  // The accept edge only latches the command; UIR starts one clk later so
  // the first tck period begins from a clean, already-loaded shift register.
  // tdi is only ever updated on a period end, i.e. while tck falls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      cmd_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_ir_out <= '0;
      vji_ir_in   <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      tdo_bit     <= 1'b0;
      vji_tdi     <= 1'b0;
      vji_rti     <= 1'b1;
      vji_uir     <= 1'b0;
      vji_cdr     <= 1'b0;
      vji_sdr     <= 1'b0;
      vji_udr     <= 1'b0;
    end else begin
      if (tck_rise && state == ST_CDR) resp_ir_out <= vji_ir_out;
      if (tck_rise && state == ST_SDR) tdo_bit <= vji_tdo;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            state   <= ST_UIR;
            vji_rti <= 1'b0;
            vji_uir <= 1'b1;
          end else if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            pending   <= 1'b1;
            vji_ir_in <= cmd_ir;
            shift_q   <= cmd_data;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_UIR: if (tck_end) begin
          state   <= ST_CDR;
          vji_uir <= 1'b0;
          vji_cdr <= 1'b1;
        end
        ST_CDR: if (tck_end) begin
          state   <= ST_SDR;
          vji_cdr <= 1'b0;
          vji_sdr <= 1'b1;
          vji_tdi <= shift_q[0];
          bit_cnt <= '0;
        end
        ST_SDR: if (tck_end) begin
          // Captured bit enters at the MSB; the next outgoing bit is the
          // current shift_q[1], which becomes shift_q[0] on this edge.
          shift_q <= {tdo_bit, shift_q[SR_WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state   <= ST_UDR;
            vji_sdr <= 1'b0;
            vji_udr <= 1'b1;
            vji_tdi <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            vji_tdi <= shift_q[1];
          end
        end
        ST_UDR: if (tck_end) begin
          state   <= ST_RTI;
          vji_udr <= 1'b0;
          vji_rti <= 1'b1;
        end
        ST_RTI: if (tck_end) begin
          state      <= ST_RESP;
          vji_rti    <= 1'b0;
          resp_valid <= 1'b1;
          resp_data  <= shift_q;
        end
        ST_RESP: if (resp_ready) begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          vji_rti    <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crossy_robbers_soc_debug_jtag_host.sv
// Self-checking bench for crossy_robbers_soc_debug_jtag_host.
// A behavioural debug slave answers each SDR period with one bit of a chosen
// word (or with tdi looped back one tck period late); expected responses are
// computed from those rules with plain arithmetic.
module tb_crossy_robbers_soc_debug_jtag_host;
  import crossy_robbers_soc_debug_pkg::*;

  localparam int SR   = 38;
  localparam int IR   = 2;
  localparam int DIV  = 2;
  localparam int LAT  = 1 + (SR + 4) * 2 * DIV;
  localparam int LAT1 = 1 + (SR + 4) * 2 * 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, resp_valid, resp_ready;
  logic [IR-1:0] cmd_ir, resp_ir_out, vji_ir_in, vji_ir_out;
  logic [SR-1:0] cmd_data, resp_data;
  logic          vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
  logic          vji_tdo;

  logic          c1_valid, c1_ready, r1_valid, r1_ready;
  logic [IR-1:0] c1_ir, r1_ir_out, d1_ir_in;
  logic [SR-1:0] c1_data, r1_data;
  logic          d1_tck, d1_tdi, d1_rti, d1_uir, d1_cdr, d1_sdr, d1_udr;

  always #5 clk = ~clk;

  crossy_robbers_soc_debug_jtag_host #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_ir_out(resp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_rti(vji_rti), .vji_uir(vji_uir),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_ir_in(vji_ir_in),
    .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  crossy_robbers_soc_debug_jtag_host #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_data(c1_data),
    .resp_valid(r1_valid), .resp_ready(r1_ready), .resp_data(r1_data),
    .resp_ir_out(r1_ir_out),
    .vji_tck(d1_tck), .vji_tdi(d1_tdi), .vji_rti(d1_rti), .vji_uir(d1_uir),
    .vji_cdr(d1_cdr), .vji_sdr(d1_sdr), .vji_udr(d1_udr), .vji_ir_in(d1_ir_in),
    .vji_tdo(1'b0), .vji_ir_out(2'b11)
  );

  typedef struct {
    logic [IR-1:0] ir;
    logic [SR-1:0] data;
    bit            loopback;
    logic [SR-1:0] word;
    logic [IR-1:0] ir_out;
    int            hold;
    logic [SR-1:0] exp_data;
    logic [IR-1:0] exp_ir;
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model state, owned by the initial block.
  bit            cur_loop;
  logic [SR-1:0] cur_word;
  int            sdr_base;

  // Per-tck-period observations, owned by the monitors below.
  int            n_uir, n_cdr, n_sdr, n_udr, n_rti;
  logic [IR-1:0] ir_seen;
  bit            held_tdi;
  int            tdi_bad, onehot_bad;
  bit            prev_tck, prev_tdi;
  logic [SR-1:0] slave_word;

  assign slave_word = cur_word >> (n_sdr - sdr_base);

  always @(posedge vji_tck) begin
    if (vji_uir) begin
      n_uir   <= n_uir + 1;
      ir_seen <= vji_ir_in;
    end
    if (vji_cdr) n_cdr <= n_cdr + 1;
    if (vji_sdr) n_sdr <= n_sdr + 1;
    if (vji_udr) n_udr <= n_udr + 1;
    if (vji_rti) n_rti <= n_rti + 1;
    held_tdi <= vji_tdi;
  end

  // The slave changes tdo only while tck falls, like a real TAP.
  always @(negedge vji_tck) begin
    vji_tdo <= cur_loop ? held_tdi : slave_word[0];
  end

  // tdi may change only on a falling tck; one strobe must be active while tck is high.
  always @(negedge clk) begin
    if (vji_tdi != prev_tdi && !(prev_tck && !vji_tck)) tdi_bad <= tdi_bad + 1;
    if (vji_tck && ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1))
      onehot_bad <= onehot_bad + 1;
    prev_tck <= vji_tck;
    prev_tdi <= vji_tdi;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [SR-1:0] rand_word();
    return SR'({$urandom(), $urandom()});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited, lat, hold_bad;
    int b_uir, b_cdr, b_sdr, b_udr, b_rti, b_tdi, b_oh;
    logic [SR-1:0] got;
    cur_loop   = v.loopback;
    cur_word   = v.word;
    vji_ir_out = v.ir_out;
    @(negedge clk);
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait", 64'(waited), 64'(0));
    sdr_base = n_sdr;
    b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr; b_rti = n_rti;
    b_tdi = tdi_bad; b_oh = onehot_bad;
    cmd_valid = 1'b1;
    cmd_ir    = v.ir;
    cmd_data  = v.data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 2000);
    got = resp_data;
    checkOutput("latency", 64'(lat), 64'(LAT));
    checkOutput("resp_data", 64'(got), 64'(v.exp_data));
    checkOutput("resp_ir_out", 64'(resp_ir_out), 64'(v.exp_ir));
    checkOutput("ir_in_during_uir", 64'(ir_seen), 64'(v.ir));
    checkOutput("uir_periods", 64'(n_uir - b_uir), 64'(1));
    checkOutput("cdr_periods", 64'(n_cdr - b_cdr), 64'(1));
    checkOutput("sdr_periods", 64'(n_sdr - b_sdr), 64'(SR));
    checkOutput("udr_periods", 64'(n_udr - b_udr), 64'(1));
    checkOutput("rti_periods", 64'(n_rti - b_rti), 64'(1));
    checkOutput("tdi_moved_off_fall", 64'(tdi_bad - b_tdi), 64'(0));
    checkOutput("strobe_not_onehot", 64'(onehot_bad - b_oh), 64'(0));
    hold_bad = 0;
    repeat (v.hold) begin
      @(posedge clk);
      #1;
      if (!resp_valid || resp_data !== got || cmd_ready || vji_tck || resp_ir_out !== v.exp_ir)
        hold_bad++;
    end
    checkOutput("resp_hold_stable", 64'(hold_bad), 64'(0));
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("handshake_to_idle", 64'({resp_valid, cmd_ready, vji_rti, vji_ir_in}),
                64'({3'b011, v.ir}));
  endtask

  initial begin
    int waited, lat, seen;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ir     = '0;
    cmd_data   = '0;
    resp_ready = 1'b0;
    vji_ir_out = '0;
    c1_valid   = 1'b0;
    c1_ir      = '0;
    c1_data    = '0;
    r1_ready   = 1'b0;
    cur_loop   = 1'b0;
    cur_word   = '0;
    sdr_base   = 0;

    // Table: directed loopback and tied-high cases, then random commands.
    vecs[0].ir = IR_BREAK;  vecs[0].data = 38'h2A_5555_AAAA; vecs[0].loopback = 1'b1;
    vecs[0].word = '0;      vecs[0].ir_out = 2'b10;          vecs[0].hold = 0;
    vecs[1].ir = IR_OCIMEM; vecs[1].data = rand_word();      vecs[1].loopback = 1'b0;
    vecs[1].word = '1;      vecs[1].ir_out = 2'b01;          vecs[1].hold = 50;
    vecs[2].ir = IR_TRACECTRL; vecs[2].data = rand_word();   vecs[2].loopback = 1'b0;
    vecs[2].word = '0;      vecs[2].ir_out = 2'b11;          vecs[2].hold = 3;
    for (int i = 3; i < 8; i++) begin
      vecs[i].ir       = IR'($urandom_range(0, 3));
      vecs[i].data     = rand_word();
      vecs[i].loopback = bit'($urandom_range(0, 1));
      vecs[i].word     = rand_word();
      vecs[i].ir_out   = IR'($urandom_range(0, 3));
      vecs[i].hold     = $urandom_range(0, 5);
    end
    // Looped-back tdi is one period late: the first captured bit is the 0
    // driven before SDR, and every data bit lands one position higher.
    for (int i = 0; i < 8; i++) begin
      vecs[i].exp_data = vecs[i].loopback ? (vecs[i].data << 1) : vecs[i].word;
      vecs[i].exp_ir   = vecs[i].ir_out;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", 64'({cmd_ready, resp_valid, vji_tck, vji_tdi, vji_rti,
                                   vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(9'b000010000));
    checkOutput("reset_resp_data", 64'(resp_data), 64'(0));
    checkOutput("reset_ir", 64'({resp_ir_out, vji_ir_in}), 64'(0));
    checkOutput("reset_dut1", 64'({c1_ready, r1_valid, d1_tck, d1_tdi, d1_rti, d1_uir,
                                   d1_cdr, d1_sdr, d1_udr, d1_ir_in, r1_ir_out}),
                64'(13'b0000100000000));
    checkOutput("reset_dut1_data", 64'(r1_data), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 64'({cmd_ready, c1_ready}), 64'(2'b11));

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset asserted for one clk during the 20th SDR period.
    cur_loop   = 1'b0;
    cur_word   = rand_word();
    vji_ir_out = 2'b10;
    @(negedge clk);
    sdr_base  = n_sdr;
    cmd_valid = 1'b1;
    cmd_ir    = IR_TRACE;
    cmd_data  = rand_word();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waited = 0;
    while ((n_sdr - sdr_base) < 20 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reached_sdr20", 64'(n_sdr - sdr_base), 64'(20));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midsdr_reset_ctrl", 64'({cmd_ready, resp_valid, vji_tck, vji_tdi, vji_rti,
                                          vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(9'b000010000));
    checkOutput("midsdr_reset_data", 64'(resp_data), 64'(0));
    checkOutput("midsdr_reset_ir", 64'({resp_ir_out, vji_ir_in}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_midsdr_reset", 64'(cmd_ready), 64'(1));
    seen = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (resp_valid || vji_tck) seen++;
    end
    checkOutput("no_resp_after_reset", 64'(seen), 64'(0));
    vecs[0].ir = IR_TRACE; vecs[0].data = rand_word(); vecs[0].loopback = 1'b0;
    vecs[0].word = rand_word(); vecs[0].ir_out = 2'b01; vecs[0].hold = 2;
    vecs[0].exp_data = vecs[0].word; vecs[0].exp_ir = 2'b01;
    applyStimulus(vecs[0]);

    // TCK_DIV=1 instance with tdo tied low.
    @(negedge clk);
    checkOutput("dut1_ready", 64'(c1_ready), 64'(1));
    c1_valid = 1'b1;
    c1_ir    = IR_BREAK;
    c1_data  = rand_word();
    @(posedge clk);
    #1;
    c1_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!r1_valid && lat < 2000);
    checkOutput("dut1_latency", 64'(lat), 64'(LAT1));
    checkOutput("dut1_resp_data", 64'(r1_data), 64'(0));
    checkOutput("dut1_resp_ir_out", 64'(r1_ir_out), 64'(2'b11));
    @(negedge clk);
    r1_ready = 1'b1;
    @(posedge clk);
    #1;
    r1_ready = 1'b0;
    checkOutput("dut1_handshake", 64'({r1_valid, c1_ready}), 64'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
